axis_rr_write_arbiter: RTL and testbench
========================================

Name: axis_rr_write_arbiter

Overview:
- Shares the memory controller's single AXI-Stream write port between NUM_PORTS requesters, such as DMA engines and a CPU bridge.
- Arbitration is round-robin at packet granularity. A grant is held from the first beat until the tlast beat is accepted.
- Output is a one-deep registered stage feeding the memory controller's slave port. Full throughput is one beat per cycle.

Parameters:
- DATA_WIDTH, 32, tdata width in bits; must be a multiple of 8.
- NUM_PORTS, 4, number of requester ports; range 2 to 8.
- ID_WIDTH, 2, width of grant_id; must satisfy 2**ID_WIDTH >= NUM_PORTS.

Ports:
- axis_aclk  in  1  single clock for all ports.
- axis_aresetn  in  1  reset, asynchronous and active-low.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  requester data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tstrb  in  NUM_PORTS*(DATA_WIDTH/8)  requester byte strobes, packed the same way.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port end-of-packet.
- s_axis_tready  out  NUM_PORTS  per-port ready; at most one bit high at a time.
- m01_axis_tready  in  1  ready from the memory controller.
- m01_axis_tdata  out  DATA_WIDTH  forwarded data.
- m01_axis_tstrb  out  DATA_WIDTH/8  forwarded strobes.
- m01_axis_tvalid  out  1  forwarded valid.
- m01_axis_tlast  out  1  forwarded end-of-packet.
- grant_id  out  ID_WIDTH  index of the current or last granted port.
- busy  out  1  high while in the XFER state.

Behaviour:
- Reset values (asynchronous, all outputs):
  - s_axis_tready=0, m01_axis_tvalid=0, m01_axis_tdata=0, m01_axis_tstrb=0, m01_axis_tlast=0.
  - grant_id=0, busy=0.
  - Internal last-grant pointer = NUM_PORTS-1, so port 0 wins first.
- State machine has two states, IDLE and XFER.
- IDLE:
  - If any s_axis_tvalid is high, select the first valid port scanning upward from pointer+1, wrapping modulo NUM_PORTS.
  - Register the selection as grant_id, set pointer = grant_id, and go to XFER next cycle.
  - If no port is valid, stay in IDLE.
  - s_axis_tready is all zero in IDLE.
- XFER:
  - s_axis_tready[grant_id] = (~m01_axis_tvalid | m01_axis_tready). All other bits are 0. This term is combinational.
  - A beat is accepted when s_axis_tvalid[g] and s_axis_tready[g] are both high. On acceptance, the output register loads tdata, tstrb and tlast of port g, and sets m01_axis_tvalid=1.
  - When the output is taken (m01_axis_tready=1) with no new beat accepted, m01_axis_tvalid is cleared to 0. tdata is held.
  - An accepted beat with tlast=1 returns the FSM to IDLE next cycle.
  - Gaps (tvalid low mid-packet) keep the grant. No other port may interleave.
- Latency:
  - A first beat presented in cycle N appears on m01 in cycle N+2: grant in N+1, register in N+2.
  - Subsequent beats take 1 cycle each.
  - Re-arbitration costs 1 idle cycle after each tlast.
- AXI-Stream rules:
  - m01 outputs are stable while m01_axis_tvalid=1 and m01_axis_tready=0.
  - Accept and drain in the same cycle is allowed; the register reloads with no bubble.
- Fairness: after port i completes a packet, every other valid port is served before port i again.
- Boundary conditions:
  - A requester dropping tvalid in the same cycle as the grant has no effect; the FSM still enters XFER and waits for its beat.
  - A single-beat packet (tlast on the first beat) is legal.
  - Reset asserted mid-packet immediately clears all state. A partial packet is dropped, not completed.

Optional Feature:
- Macro: AXIS_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index valid port wins in IDLE, and the pointer is unused. Packet locking is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
1. Reset, then port 0 sends one beat, tdata=0xDEADBEEF, tstrb=0xF, tlast=1, with m01_axis_tready=1:
   - m01_axis_tvalid=1 with that data exactly 2 cycles later.
   - grant_id=0, then FSM returns to IDLE.
2. Ports 0-3 all hold valid with 2-beat packets:
   - Grant order is 0,1,2,3,0.
   - Beats are never interleaved; each packet's tlast lands on its second beat.
3. Back-pressure: m01_axis_tready=0 for 5 cycles mid-packet:
   - m01 outputs are stable throughout.
   - s_axis_tready[g]=0 while the output register is full.
   - No beat is lost or duplicated on release.
4. Port 1 presents a 4-beat packet with tvalid low on beat 3 for 3 cycles, while port 2 is valid:
   - Grant stays on 1 until its tlast.
   - Port 2 is granted only after that.
5. Reset pulse during beat 2 of a 4-beat packet:
   - All outputs are 0 asynchronously.
   - After release, port 0 wins first.
6. With AXIS_ARB_FIXED_PRIO_EN defined, ports 0 and 3 continuously valid:
   - Port 0 is always granted.
   - Port 3 is never granted while port 0 remains valid.

Source files
------------

// File: rtl/axis_rr_write_arbiter_if.sv
// Purpose : AXI-Stream bundle carrying LANES side-by-side streams (tdata/tstrb packed lane i at [i*W +: W]).
// Latency : none, wiring only.
// Backpressure: per-lane tready; the master modport drives payload/valid, the slave modport drives tready.
interface axis_rr_write_arbiter_if #(
    parameter int LANES      = 1,
    parameter int DATA_WIDTH = 32
);
    logic [LANES*DATA_WIDTH-1:0]     tdata;
    logic [LANES*(DATA_WIDTH/8)-1:0] tstrb;
    logic [LANES-1:0]                tvalid;
    logic [LANES-1:0]                tlast;
    logic [LANES-1:0]                tready;

    modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_rr_write_arbiter.sv
// Purpose : packet-granular arbiter sharing one AXI-Stream write port among NUM_PORTS requesters.
// Latency : first beat 2 cycles (grant, then output register); following beats 1 cycle; 1 idle cycle per re-arbitration.
// Backpressure: granted port sees tready only while the one-deep output register is empty or draining.
//
// Ports: axis_aclk / axis_aresetn (async active-low); s_axis (slave, NUM_PORTS lanes of requesters);
//        m01_axis (master, single lane to the memory controller); grant_id (current/last grant); busy (packet in flight).
// Optional: define AXIS_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module axis_rr_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                    axis_aclk,
    input  logic                    axis_aresetn,
    axis_rr_write_arbiter_if.slave  s_axis,
    axis_rr_write_arbiter_if.master m01_axis,
    output logic [ID_WIDTH-1:0]     grant_id,
    output logic                    busy
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     grant_q, grant_d;
    logic [ID_WIDTH-1:0]     pick;
    logic                    pick_vld;
    logic [NUM_PORTS-1:0]    s_rdy;

    logic                    out_vld_q;
    logic [DATA_WIDTH-1:0]   out_dat_q;
    logic [STRB_WIDTH-1:0]   out_strb_q;
    logic                    out_last_q;

    logic                    slot_free;
    logic                    accept;
    logic                    g_vld;
    logic                    g_last;
    logic [DATA_WIDTH-1:0]   g_dat;
    logic [STRB_WIDTH-1:0]   g_strb;

`ifdef AXIS_ARB_FIXED_PRIO_EN
    // Lowest valid index wins; scanning downward lets the lowest overwrite.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (s_axis.tvalid[k]) begin
                pick     = ID_WIDTH'(k);
                pick_vld = 1'b1;
            end
        end
    end
`else
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [ID_WIDTH-1:0] scan_idx;

    // Scan ptr+NUM_PORTS down to ptr+1 so the last hit is the first valid port after ptr.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        scan_idx = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            scan_idx = ID_WIDTH'((int'(ptr_q) + k) % NUM_PORTS);
            if (s_axis.tvalid[scan_idx]) begin
                pick     = scan_idx;
                pick_vld = 1'b1;
            end
        end
    end

    // Pointer starts at the top port so port 0 wins the first arbitration after reset.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            ptr_q <= ID_WIDTH'(NUM_PORTS - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Granted-port mux.
    assign g_vld  = s_axis.tvalid[grant_q];
    assign g_last = s_axis.tlast[grant_q];
    assign g_dat  = s_axis.tdata[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
    assign g_strb = s_axis.tstrb[int'(grant_q) * STRB_WIDTH +: STRB_WIDTH];

    // Output slot can take a beat when empty or when its content leaves this cycle.
    assign slot_free = ~out_vld_q | m01_axis.tready;
    assign accept    = (state_q == XFER) & g_vld & slot_free;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        s_rdy   = '0;
`ifndef AXIS_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = XFER;
                    grant_d = pick;
`ifndef AXIS_ARB_FIXED_PRIO_EN
                    ptr_d   = pick;
`endif
                end
            end
            XFER: begin
                s_rdy[grant_q] = slot_free;
                // Grant is held through gaps until the tlast beat is taken.
                if (accept && g_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // One-deep output register; accept-and-drain in one cycle reloads without a bubble.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_strb_q <= '0;
            out_last_q <= 1'b0;
        end else if (accept) begin
            out_vld_q  <= 1'b1;
            out_dat_q  <= g_dat;
            out_strb_q <= g_strb;
            out_last_q <= g_last;
        end else if (m01_axis.tready) begin
            out_vld_q  <= 1'b0;
        end
    end

    assign s_axis.tready   = s_rdy;
    assign m01_axis.tvalid = out_vld_q;
    assign m01_axis.tdata  = out_dat_q;
    assign m01_axis.tstrb  = out_strb_q;
    assign m01_axis.tlast  = out_last_q;
    assign grant_id        = grant_q;
    assign busy            = (state_q == XFER);
endmodule

// File: tb/tb_axis_rr_write_arbiter.sv
// Purpose : self-checking bench for axis_rr_write_arbiter with a packet-level reference model.
// Latency : checks first-beat latency of 2 cycles and packet ordering.
// Backpressure: random and forced sink stalls; output stability and input tready checked every cycle.
module tb_axis_rr_write_arbiter;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    axis_rr_write_arbiter_if #(.LANES(NP), .DATA_WIDTH(DW)) s_if ();
    axis_rr_write_arbiter_if #(.LANES(1),  .DATA_WIDTH(DW)) m_if ();
    logic [IW-1:0] grant_id;
    logic          busy;

    axis_rr_write_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .ID_WIDTH(IW)) dut (
        .axis_aclk    (clk),
        .axis_aresetn (arst_n),
        .s_axis       (s_if),
        .m01_axis     (m_if),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic          l;
    } beat_t;

    beat_t drv_q [NP][$];
    beat_t snk_q [NP][$];
    int    snk_pk [NP];
    int    drv_beat [NP];
    logic  drv_vld [NP];
    int    stall_beat [NP];
    int    stall_len [NP];
    int    stall_cnt [NP];
    int    gap_pct [NP];
    int    rdy_pct, hold, cyc, snk_prev, snk_cur;
    int    start_log [$];
    int    vec = 0;
    int    miss = 0;
    logic  prev_stall;
    beat_t saved;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next packet owner: the first port after the previous owner that still owes packets.
    function automatic int next_port();
`ifdef AXIS_ARB_FIXED_PRIO_EN
        for (int p = 0; p < NP; p++)
            if (snk_pk[p] > 0) return p;
`else
        for (int k = 1; k <= NP; k++)
            if (snk_pk[(snk_prev + k) % NP] > 0) return (snk_prev + k) % NP;
`endif
        return -1;
    endfunction

    task automatic model_clear();
        for (int p = 0; p < NP; p++) begin
            drv_q[p].delete();
            snk_q[p].delete();
            snk_pk[p]     = 0;
            drv_beat[p]   = 0;
            drv_vld[p]    = 1'b0;
            stall_beat[p] = -1;
            stall_len[p]  = 0;
            stall_cnt[p]  = 0;
            gap_pct[p]    = 0;
        end
        start_log.delete();
        snk_prev   = NP - 1;
        snk_cur    = -1;
        prev_stall = 1'b0;
        hold       = 0;
        rdy_pct    = 100;
        s_if.tvalid = '0;
        s_if.tlast  = '0;
        s_if.tdata  = '0;
        s_if.tstrb  = '0;
        m_if.tready = 1'b0;
    endtask

    task automatic add_beat(input int p, input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        beat_t b;
        b.d = d; b.s = s; b.l = l;
        drv_q[p].push_back(b);
        snk_q[p].push_back(b);
        if (l) snk_pk[p]++;
    endtask

    task automatic add_pkt(input int p, input int len);
        for (int b = 0; b < len; b++)
            add_beat(p, $urandom, SW'($urandom_range(1, 15)), (b == len - 1));
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_m_tvalid"}, m_if.tvalid, 0);
        chk({pfx, "_m_tdata"},  m_if.tdata, 0);
        chk({pfx, "_m_tstrb"},  m_if.tstrb, 0);
        chk({pfx, "_m_tlast"},  m_if.tlast, 0);
        chk({pfx, "_s_tready"}, s_if.tready, 0);
        chk({pfx, "_grant_id"}, grant_id, 0);
        chk({pfx, "_busy"},     busy, 0);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        model_clear();
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    // One clock: drive at negedge, sample 1 time unit later, book the handshakes of the coming posedge.
    task automatic cycle();
        beat_t e;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            if (!drv_vld[p] && drv_q[p].size() > 0) begin
                if (drv_beat[p] == stall_beat[p] && stall_cnt[p] < stall_len[p]) stall_cnt[p]++;
                else if (drv_beat[p] == 0) drv_vld[p] = 1'b1;
                else drv_vld[p] = ($urandom_range(0, 99) >= gap_pct[p]);
            end
            s_if.tvalid[p] = drv_vld[p];
            if (drv_vld[p]) begin
                s_if.tdata[p*DW +: DW] = drv_q[p][0].d;
                s_if.tstrb[p*SW +: SW] = drv_q[p][0].s;
                s_if.tlast[p]          = drv_q[p][0].l;
            end else begin
                s_if.tdata[p*DW +: DW] = $urandom;
                s_if.tstrb[p*SW +: SW] = SW'($urandom);
                s_if.tlast[p]          = 1'($urandom_range(0, 1));
            end
        end
        if (hold > 0) begin
            m_if.tready = 1'b0;
            hold--;
        end else begin
            m_if.tready = ($urandom_range(0, 99) < rdy_pct);
        end
        #1;
        chk("tready_onehot0", ($countones(s_if.tready) <= 1), 1);
        if (prev_stall) begin
            chk("stall_tvalid", m_if.tvalid, 1);
            chk("stall_tdata",  m_if.tdata,  saved.d);
            chk("stall_tstrb",  m_if.tstrb,  saved.s);
            chk("stall_tlast",  m_if.tlast,  saved.l);
        end
        if (m_if.tvalid && !m_if.tready) chk("tready_while_full", s_if.tready, 0);
        for (int p = 0; p < NP; p++) begin
            if (drv_vld[p] && s_if.tready[p]) begin
                chk("accept_grant_id", grant_id, p);
                chk("accept_busy", busy, 1);
                drv_beat[p] = drv_q[p][0].l ? 0 : drv_beat[p] + 1;
                void'(drv_q[p].pop_front());
                drv_vld[p] = 1'b0;
            end
        end
        if (m_if.tvalid && m_if.tready) begin
            if (snk_cur < 0) begin
                snk_cur = next_port();
                start_log.push_back(snk_cur);
            end
            chk("beat_expected", (snk_cur >= 0), 1);
            if (snk_cur >= 0) begin
                e = snk_q[snk_cur].pop_front();
                chk("out_tdata", m_if.tdata, e.d);
                chk("out_tstrb", m_if.tstrb, e.s);
                chk("out_tlast", m_if.tlast, e.l);
                if (e.l) begin
                    snk_pk[snk_cur]--;
                    snk_prev = snk_cur;
                    snk_cur  = -1;
                end
            end
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        saved.d = m_if.tdata;
        saved.s = m_if.tstrb;
        saved.l = m_if.tlast;
        cyc++;
    endtask

    task automatic drain(input int limit);
        int left;
        for (int i = 0; i < limit; i++) begin
            left = 0;
            for (int p = 0; p < NP; p++) left += snk_q[p].size();
            if (left == 0) break;
            cycle();
        end
        left = 0;
        for (int p = 0; p < NP; p++) left += snk_q[p].size();
        chk("drain_left", left, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, lat;
        int exp_order [5];
        cyc = 0;

        // Step 1: single-beat packet on port 0, latency 2.
        do_reset();
        add_beat(0, 32'hDEADBEEF, 4'hF, 1'b1);
        k0 = cyc;
        lat = -1;
        for (int j = 0; j < 10; j++) begin
            cycle();
            if (j == 1) begin
                chk("t1_busy_xfer", busy, 1);
                chk("t1_grant", grant_id, 0);
            end
            if (m_if.tvalid) begin
                lat = cyc - k0 - 1;
                break;
            end
        end
        chk("t1_latency", lat, 2);
        chk("t1_tdata", m_if.tdata, 32'hDEADBEEF);
        chk("t1_tstrb", m_if.tstrb, 4'hF);
        chk("t1_tlast", m_if.tlast, 1);
        chk("t1_idle_after", busy, 0);
        chk("t1_grant_after", grant_id, 0);
        drain(20);

        // Step 2: all ports with 2-beat packets.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) add_pkt(p, 2);
        drain(300);
`ifdef AXIS_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 1, 1, 2};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        chk("t2_pkt_count", start_log.size(), 2 * NP);
        for (int i = 0; i < 5; i++) chk("t2_grant_order", start_log[i], exp_order[i]);

        // Step 3: 5-cycle sink stall mid-packet.
        do_reset();
        add_pkt(0, 6);
        for (int i = 0; i < 4; i++) cycle();
        hold = 5;
        drain(100);

        // Step 4: port 1 stalls before beat 3 while port 2 waits.
        do_reset();
        stall_beat[1] = 2;
        stall_len[1]  = 3;
        add_pkt(1, 4);
        add_pkt(2, 2);
        drain(100);
        chk("t4_pkt_count", start_log.size(), 2);
        chk("t4_first", start_log[0], 1);
        chk("t4_second", start_log[1], 2);

        // Step 5: async reset during beat 2 of a 4-beat packet.
        do_reset();
        add_pkt(2, 4);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (drv_beat[2] >= 2) break;
        end
        @(posedge clk);
        #2;
        chk("t5_vld_before", m_if.tvalid, 1);
        arst_n = 1'b0;
        #1;
        chk_reset_vals("t5_async");
        model_clear();
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        add_pkt(2, 1);
        add_pkt(0, 1);
        drain(50);
        chk("t5_pkt_count", start_log.size(), 2);
        chk("t5_first", start_log[0], 0);
        chk("t5_second", start_log[1], 2);

        // Randomized traffic with gaps and random sink readiness.
        do_reset();
        for (int round = 0; round < 3; round++) begin
            rdy_pct = 70;
            for (int p = 0; p < NP; p++) begin
                gap_pct[p] = 30;
                for (int n = $urandom_range(1, 4); n > 0; n--) add_pkt(p, $urandom_range(1, 5));
            end
            drain(3000);
        end

`ifdef AXIS_ARB_FIXED_PRIO_EN
        // Step 6: fixed priority, ports 0 and 3 both busy.
        do_reset();
        for (int i = 0; i < 4; i++) add_pkt(0, 2);
        for (int i = 0; i < 2; i++) add_pkt(3, 2);
        drain(200);
        chk("t6_pkt_count", start_log.size(), 6);
        for (int i = 0; i < 4; i++) chk("t6_port0_first", start_log[i], 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
